// File: rtl/monolith_axi_regs.sv
// AXI4-Lite register front-end for the Monolith M31 hash core: IN1/IN2/OUT/CTRL map, start pulse, digest capture, irq.
// Optional feature macro MONOLITH_AXI_IRQ_EN adds the CTRL[1] irq_en bit and gates irq with it.
module monolith_axi_regs #(
    parameter int ADDR_W = 4,
    parameter int FW     = 31
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [FW-1:0]     core_in1,
    output logic [FW-1:0]     core_in2,
    output logic              core_start,
    input  logic              core_valid,
    input  logic [FW-1:0]     core_out,
    output logic              irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] A_IN1  = ADDR_W'(4'h0);
    localparam logic [ADDR_W-1:0] A_IN2  = ADDR_W'(4'h4);
    localparam logic [ADDR_W-1:0] A_OUT  = ADDR_W'(4'h8);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(4'hC);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t        state_q, state_d;
    logic          awready_q, awready_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [FW-1:0] in1_q, in1_d;
    logic [FW-1:0] in2_q, in2_d;
    logic [FW-1:0] out_q, out_d;
    logic          valid_q, valid_d;
    logic          go_q, go_d;
    logic          start_q, start_d;
    logic          irq_en_q, irq_en_d;
    logic          irq_q, irq_d;

    logic          wr_en, rd_en, go_hit, go_set, go_clr, cap_ok;
    logic [31:0]   strb_mask, in1_merge, in2_merge, ctrl_rd;
    logic [FW-1:0] in1_new, in2_new;

    assign wr_en  = awready_q & s_axi_awvalid & s_axi_wvalid;
    assign rd_en  = arready_q & s_axi_arvalid;
    assign go_hit = wr_en & (s_axi_awaddr == A_CTRL) & s_axi_wstrb[0];
    assign go_set = go_hit & s_axi_wdata[0];
    assign go_clr = go_hit & ~s_axi_wdata[0];
    // The core's valid is a level that may still be high from the previous hash
    // while the start pulse is out, so it is only trusted once start has gone.
    assign cap_ok = core_valid & ~start_q;

    assign strb_mask = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}},
                        {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
    assign in1_merge = (32'(in1_q) & ~strb_mask) | (s_axi_wdata & strb_mask);
    assign in2_merge = (32'(in2_q) & ~strb_mask) | (s_axi_wdata & strb_mask);
    assign in1_new   = (in1_merge[FW-1:0] == {FW{1'b1}}) ? '0 : in1_merge[FW-1:0];
    assign in2_new   = (in2_merge[FW-1:0] == {FW{1'b1}}) ? '0 : in2_merge[FW-1:0];

`ifdef MONOLITH_AXI_IRQ_EN
    assign ctrl_rd = {30'b0, irq_en_q, go_q};
`else
    assign ctrl_rd = {30'b0, 1'b0, go_q};
`endif

    always_comb begin
        state_d   = state_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        out_d     = out_q;
        valid_d   = valid_q;
        go_d      = go_q;
        start_d   = 1'b0;
        irq_en_d  = irq_en_q;
        awready_d = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
        arready_d = s_axi_arvalid & ~rvalid_q & ~arready_q;

        if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
        if (wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            if (s_axi_awaddr == A_IN1) begin
                if (state_q == S_RUN) bresp_d = RESP_SLVERR;
                else                  in1_d   = in1_new;
            end else if (s_axi_awaddr == A_IN2) begin
                if (state_q == S_RUN) bresp_d = RESP_SLVERR;
                else                  in2_d   = in2_new;
            end
        end
        if (go_hit) begin
            go_d = s_axi_wdata[0];
`ifdef MONOLITH_AXI_IRQ_EN
            irq_en_d = s_axi_wdata[1];
`endif
        end

        if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
        if (rd_en) begin
            rvalid_d = 1'b1;
            if      (s_axi_araddr == A_IN1)  rdata_d = 32'(in1_q);
            else if (s_axi_araddr == A_IN2)  rdata_d = 32'(in2_q);
            else if (s_axi_araddr == A_OUT)  rdata_d = 32'({out_q, valid_q});
            else if (s_axi_araddr == A_CTRL) rdata_d = ctrl_rd;
            else                             rdata_d = 32'h0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (go_set) begin
                    start_d = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cap_ok) begin
                    out_d   = core_out;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A stop overrides everything, including a capture on the same edge.
        if (go_clr) begin
            out_d   = out_q;
            valid_d = 1'b0;
            state_d = S_IDLE;
        end

`ifdef MONOLITH_AXI_IRQ_EN
        irq_d = valid_d & irq_en_d;
`else
        irq_d = valid_d;
`endif
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            in1_q     <= '0;
            in2_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            go_q      <= 1'b0;
            start_q   <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            go_q      <= go_d;
            start_q   <= start_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign core_in1      = in1_q;
    assign core_in2      = in2_q;
    assign core_start    = start_q;
    assign irq           = irq_q;

endmodule
